// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder slice.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        s_IDLE,
        s_WAIT_DONE,
        s_WAIT_IDLE
    } feeder_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with registered occupancy, full/empty flags and a one-cycle
// overflow pulse when a write arrives while full.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Wr_DV,
    input  logic [UART_DATA_W-1:0] i_Wr_Byte,
    input  logic                   i_Rd_En,
    output logic [UART_DATA_W-1:0] o_Rd_Byte,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [ADDR_W:0]        o_Count,
    output logic                   o_Overflow
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      rd_ptr;
    logic [ADDR_W:0]        count_nx;
    logic                   push;
    logic                   pop;

    // Full/empty come from the pre-edge registered flags, so a write while full
    // is dropped even if a pop happens on the same edge.
    assign push      = i_Wr_DV && !o_Full;
    assign pop       = i_Rd_En && !o_Empty;
    assign o_Rd_Byte = mem[rd_ptr];

    always_comb begin
        count_nx = o_Count;
        if (push && !pop)
            count_nx = o_Count + CNT_ONE;
        else if (!push && pop)
            count_nx = o_Count - CNT_ONE;
    end

    always_ff @(posedge i_Clock) begin
        if (push)
            mem[wr_ptr] <= i_Wr_Byte;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_Full     <= 1'b0;
            o_Empty    <= 1'b1;
            o_Overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            o_Count    <= count_nx;
            o_Full     <= (count_nx == FULL_CNT);
            o_Empty    <= (count_nx == '0);
            o_Overflow <= i_Wr_DV && o_Full;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and launches them one at a time into the UART transmitter
// over its DV / Active / Done handshake.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Wr_DV,
    input  logic [UART_DATA_W-1:0] i_Wr_Byte,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [ADDR_W:0]        o_Count,
    output logic                   o_Overflow,
    output logic                   o_Busy,
    output logic                   o_Tx_DV,
    output logic [UART_DATA_W-1:0] o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done
);

    feeder_state_t          state;
    logic                   launch;
    logic [UART_DATA_W-1:0] rd_byte;

    // The transmitter has no reset, so never launch while it still reports activity.
    assign launch = (state == s_IDLE) && !o_Empty && !i_Tx_Active && !i_Tx_Done;

    uart_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Wr_DV   (i_Wr_DV),
        .i_Wr_Byte (i_Wr_Byte),
        .i_Rd_En   (launch),
        .o_Rd_Byte (rd_byte),
        .o_Full    (o_Full),
        .o_Empty   (o_Empty),
        .o_Count   (o_Count),
        .o_Overflow(o_Overflow)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= s_IDLE;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= '0;
            o_Busy    <= 1'b0;
        end else begin
            o_Tx_DV <= 1'b0;
            case (state)
                s_IDLE: begin
                    if (launch) begin
                        o_Tx_DV   <= 1'b1;
                        o_Tx_Byte <= rd_byte;
                        o_Busy    <= 1'b1;
                        state     <= s_WAIT_DONE;
                    end
                end
                s_WAIT_DONE: begin
                    if (i_Tx_Done)
                        state <= s_WAIT_IDLE;
                end
                s_WAIT_IDLE: begin
                    if (!i_Tx_Done && !i_Tx_Active) begin
                        o_Busy <= 1'b0;
                        state  <= s_IDLE;
                    end
                end
                default: begin
                    o_Busy <= 1'b0;
                    state  <= s_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder with a behavioural unreset transmitter (4 clocks/bit)
// and a serial-line receiver that reconstructs the transmitted bytes.
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_dv = 1'b0;
    logic [7:0] wr_byte = 8'h00;
    logic       hold_active = 1'b0;
    logic       full, empty, ovf, busy, tx_dv;
    logic [4:0] count;
    logic [7:0] tx_byte;

    typedef enum {T_IDLE, T_START, T_DATA, T_STOP, T_CLEAN} tx_st_t;
    tx_st_t     tx_st = T_IDLE;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_serial = 1'b1;
    logic [7:0] tx_data = 8'h00;
    int         tx_cnt = 0;
    int         tx_bit = 0;

    int         checks = 0;
    int         failures = 0;
    int         dv_count = 0;
    int         dv_viol = 0;
    int         rx_bad = 0;
    logic       dv_prev = 1'b0;
    logic [7:0] rx_q[$];

    typedef struct {
        logic       wr;
        logic [7:0] b;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       ovf;
    } vec_t;
    vec_t vecs[18];

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(16)) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Wr_DV    (wr_dv),
        .i_Wr_Byte  (wr_byte),
        .o_Full     (full),
        .o_Empty    (empty),
        .o_Count    (count),
        .o_Overflow (ovf),
        .o_Busy     (busy),
        .o_Tx_DV    (tx_dv),
        .o_Tx_Byte  (tx_byte),
        .i_Tx_Active(tx_active | hold_active),
        .i_Tx_Done  (tx_done)
    );

    // Transmitter model: no reset, Done high for two cycles after the stop bit.
    always @(posedge clk) begin
        case (tx_st)
            T_IDLE: begin
                tx_serial <= 1'b1;
                tx_done   <= 1'b0;
                tx_cnt    <= 0;
                tx_bit    <= 0;
                if (tx_dv) begin
                    tx_active <= 1'b1;
                    tx_data   <= tx_byte;
                    tx_st     <= T_START;
                end
            end
            T_START: begin
                tx_serial <= 1'b0;
                if (tx_cnt < 3) tx_cnt <= tx_cnt + 1;
                else begin tx_cnt <= 0; tx_st <= T_DATA; end
            end
            T_DATA: begin
                tx_serial <= tx_data[tx_bit];
                if (tx_cnt < 3) tx_cnt <= tx_cnt + 1;
                else begin
                    tx_cnt <= 0;
                    if (tx_bit < 7) tx_bit <= tx_bit + 1;
                    else begin tx_bit <= 0; tx_st <= T_STOP; end
                end
            end
            T_STOP: begin
                tx_serial <= 1'b1;
                if (tx_cnt < 3) tx_cnt <= tx_cnt + 1;
                else begin
                    tx_done   <= 1'b1;
                    tx_active <= 1'b0;
                    tx_st     <= T_CLEAN;
                end
            end
            default: begin
                tx_done <= 1'b1;
                tx_st   <= T_IDLE;
            end
        endcase
    end

    // Launch monitor: DV must be a single-cycle pulse into an idle transmitter.
    always @(posedge clk) begin
        if (tx_dv) begin
            dv_count = dv_count + 1;
            if (tx_active || tx_done || hold_active || dv_prev)
                dv_viol = dv_viol + 1;
        end
        dv_prev = tx_dv;
    end

    // Serial receiver: samples mid-bit, LSB first, verifies start and stop bits.
    initial begin
        logic [7:0] rb;
        forever begin
            @(negedge tx_serial);
            repeat (2) @(posedge clk);
            if (tx_serial == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge clk);
                    rb[i] = tx_serial;
                end
                repeat (4) @(posedge clk);
                if (tx_serial !== 1'b1) rx_bad = rx_bad + 1;
                rx_q.push_back(rb);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int k = 0; k < budget && rx_q.size() < n; k++) step();
        check("rx_timeout", 32'(rx_q.size() >= n), 32'd1);
    endtask

    initial begin
        int rx_base;
        int dv_base;

        for (int i = 0; i < 16; i++)
            vecs[i] = '{1'b1, 8'(i + 1), 5'(i + 1), (i == 15), 1'b0, 1'b0};
        vecs[16] = '{1'b1, 8'hFF, 5'd16, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 1'b0};

        // Reset, load two bytes, then reset asynchronously mid-cycle.
        hold_active = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        wr_dv = 1'b1; wr_byte = 8'h5A;
        step(); step();
        wr_dv = 1'b0;
        check("pre_reset_count", 32'(count), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dv", 32'(tx_dv), 32'd0);
        check("rst_byte", 32'(tx_byte), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill while the transmitter is stalled, then overflow with 8'hFF.
        for (int i = 0; i < 18; i++) begin
            wr_dv = vecs[i].wr;
            wr_byte = vecs[i].b;
            step();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
        end
        wr_dv = 1'b0;
        rx_base = rx_q.size();
        hold_active = 1'b0;
        wait_rx(rx_base + 16, 2000);
        repeat (10) step();
        check("burst_frames", 32'(rx_q.size() - rx_base), 32'd16);
        for (int i = 0; i < 16 && rx_base + i < rx_q.size(); i++)
            check($sformatf("burst_byte%0d", i), 32'(rx_q[rx_base + i]), 32'(i + 1));
        check("burst_empty", 32'(empty), 32'd1);
        check("burst_count", 32'(count), 32'd0);
        check("burst_busy", 32'(busy), 32'd0);
        rx_base = rx_q.size();

        // Single byte: launch DV appears on the second edge after the write.
        wr_dv = 1'b1; wr_byte = 8'hA5;
        step();
        wr_dv = 1'b0;
        check("single_count1", 32'(count), 32'd1);
        check("single_dv_early", 32'(tx_dv), 32'd0);
        step();
        check("single_dv", 32'(tx_dv), 32'd1);
        check("single_byte", 32'(tx_byte), 32'hA5);
        check("single_count0", 32'(count), 32'd0);
        check("single_busy", 32'(busy), 32'd1);
        step();
        check("single_dv_pulse", 32'(tx_dv), 32'd0);
        check("single_byte_hold", 32'(tx_byte), 32'hA5);
        wait_rx(rx_base + 1, 200);
        repeat (10) step();
        if (rx_q.size() > rx_base) check("single_serial", 32'(rx_q[rx_base]), 32'hA5);
        rx_base = rx_q.size();

        // Push and pop on the same edge at count 3.
        hold_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_dv = 1'b1; wr_byte = 8'(8'h61 + i);
            step();
        end
        check("pp_count_pre", 32'(count), 32'd3);
        hold_active = 1'b0;
        wr_byte = 8'h64;
        step();
        wr_dv = 1'b0;
        check("pp_count", 32'(count), 32'd3);
        check("pp_dv", 32'(tx_dv), 32'd1);
        check("pp_byte", 32'(tx_byte), 32'h61);
        wait_rx(rx_base + 4, 800);
        repeat (10) step();
        for (int i = 0; i < 4 && rx_base + i < rx_q.size(); i++)
            check($sformatf("pp_byte%0d", i), 32'(rx_q[rx_base + i]), 32'(8'h61 + i));
        rx_base = rx_q.size();

        // Reset during frame 2 of 4: frame 2 finishes, nothing else is sent.
        hold_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_dv = 1'b1; wr_byte = 8'(8'h71 + i);
            step();
        end
        wr_dv = 1'b0;
        dv_base = dv_count;
        hold_active = 1'b0;
        for (int k = 0; k < 300 && dv_count < dv_base + 2; k++) step();
        check("mid_dv_seen", 32'(dv_count - dv_base), 32'd2);
        repeat (10) step();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dv_base = dv_count;
        repeat (300) step();
        check("mid_no_dv", 32'(dv_count - dv_base), 32'd0);
        check("mid_frames", 32'(rx_q.size() - rx_base), 32'd2);
        if (rx_q.size() >= rx_base + 2) begin
            check("mid_byte0", 32'(rx_q[rx_base]), 32'h71);
            check("mid_byte1", 32'(rx_q[rx_base + 1]), 32'h72);
        end
        check("mid_empty", 32'(empty), 32'd1);

        check("dv_protocol", 32'(dv_viol), 32'd0);
        check("stop_bits", 32'(rx_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
